fetch_stage: RTL and testbench

- F stage of the pipelined Y86-64 core; sits directly upstream of decode.
- Holds the predicted-PC register and selects the fetch PC, including redirect on a mispredicted jXX and on ret.
- Splits the raw instruction bytes into icode/ifun/rA/rB/valC/valP and computes the next predicted PC.
- Registers the results into the F/D pipeline register, with stall and bubble control from hazard logic.

---
 rtl/y86_pkg.sv | 47 ++++
 rtl/instr_split.sv | 49 ++++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode/status constants, D-register layout and instruction lengths.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{stat: STAT_BUB, icode: I_NOP, ifun: 4'h0,
                                  rA: RNONE, rB: RNONE, valC: 64'h0, valP: 64'h0};

  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
      I_JXX, I_CALL:                    instr_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
      default:                          instr_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/instr_split.sv
// rtl/instr_split.sv - Combinational split of raw instruction bytes into fields, length and validity.
module instr_split
  import y86_pkg::*;
(
  input  logic [79:0] bytes_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [3:0]  len_o,
  output logic        valid_o
);

  logic regids;

  always_comb begin
    icode_o = bytes_i[7:4];
    ifun_o  = bytes_i[3:0];

    case (icode_o)
      I_RRMOVQ, I_JXX:                      valid_o = (ifun_o <= 4'd6);
      I_OPQ:                                valid_o = (ifun_o <= 4'd3);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ, I_CALL, I_RET, I_PUSHQ,
      I_POPQ:                               valid_o = (ifun_o == 4'h0);
      default:                              valid_o = 1'b0;
    endcase

    case (icode_o)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ:               regids = 1'b1;
      default:                              regids = 1'b0;
    endcase

    rA_o = regids ? bytes_i[15:12] : RNONE;
    rB_o = regids ? bytes_i[11:8]  : RNONE;

    // Branch targets follow byte0 directly; memory forms skip the register byte.
    case (icode_o)
      I_JXX, I_CALL:                 valC_o = bytes_i[71:8];
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:  valC_o = bytes_i[79:16];
      default:                       valC_o = 64'h0;
    endcase

    len_o = valid_o ? instr_len(icode_o) : 4'd1;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Y86-64 fetch: PC select, predicted PC and F/D register.
// Optional halt/error freeze enabled by FETCH_HALT_FREEZE_EN.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_data,
  input  logic        imem_error,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [63:0] F_predPC_o
);

  logic [63:0] pred_pc_q, pred_pc_d;
  d_reg_t      d_q, d_d;
  d_reg_t      fetched;

  logic        mispredict, ret_redirect, redirect;
  logic [63:0] f_pc, f_pred_pc;
  logic [3:0]  s_icode, s_ifun, s_rA, s_rB, s_len, f_len;
  logic [63:0] s_valC;
  logic        s_valid;
  logic        hold;

  assign mispredict   = (M_icode == I_JXX) && !M_Cnd;
  assign ret_redirect = (W_icode == I_RET);
  assign redirect     = mispredict || ret_redirect;

  always_comb begin
    if (mispredict)        f_pc = M_valA;
    else if (ret_redirect) f_pc = W_valM;
    else                   f_pc = pred_pc_q;
  end

  assign imem_addr = f_pc;

  instr_split u_split (
    .bytes_i (imem_data),
    .icode_o (s_icode),
    .ifun_o  (s_ifun),
    .rA_o    (s_rA),
    .rB_o    (s_rB),
    .valC_o  (s_valC),
    .len_o   (s_len),
    .valid_o (s_valid)
  );

  always_comb begin
    fetched.icode = s_icode;
    fetched.ifun  = s_ifun;
    fetched.rA    = s_rA;
    fetched.rB    = s_rB;
    fetched.valC  = s_valC;
    f_len         = s_len;
    // A failed fetch carries no usable bytes, so it degrades to a 1-byte NOP.
    if (imem_error) begin
      fetched.stat  = STAT_ADR;
      fetched.icode = I_NOP;
      fetched.rA    = RNONE;
      fetched.rB    = RNONE;
      fetched.valC  = 64'h0;
      f_len         = 4'd1;
    end else if (!s_valid) begin
      fetched.stat  = STAT_INS;
    end else if (s_icode == I_HALT) begin
      fetched.stat  = STAT_HLT;
    end else begin
      fetched.stat  = STAT_AOK;
    end
    fetched.valP = f_pc + {60'h0, f_len};
    f_pred_pc    = ((fetched.icode == I_JXX) || (fetched.icode == I_CALL)) ?
                   fetched.valC : fetched.valP;
  end

`ifdef FETCH_HALT_FREEZE_EN
  logic frozen_q, frozen_d;

  assign hold = frozen_q && !redirect;

  always_comb begin
    frozen_d = frozen_q;
    if (!D_stall && !D_bubble && !hold &&
        (fetched.stat == STAT_HLT || fetched.stat == STAT_ADR || fetched.stat == STAT_INS))
      frozen_d = 1'b1;
    else if (redirect)
      frozen_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) frozen_q <= 1'b0;
    else     frozen_q <= frozen_d;
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    pred_pc_d = pred_pc_q;
    if (!F_stall && !hold) pred_pc_d = f_pred_pc;
    d_d = d_q;
    if (!D_stall) d_d = (D_bubble || hold) ? D_BUBBLE : fetched;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_pc_q <= RESET_PC;
      d_q       <= D_BUBBLE;
    end else begin
      pred_pc_q <= pred_pc_d;
      d_q       <= d_d;
    end
  end

  assign F_predPC_o = pred_pc_q;
  assign D_stat     = d_q.stat;
  assign D_icode    = d_q.icode;
  assign D_ifun     = d_q.ifun;
  assign D_rA       = d_q.rA;
  assign D_rB       = d_q.rB;
  assign D_valC     = d_q.valC;
  assign D_valP     = d_q.valP;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Directed self-checking bench for fetch_stage (FETCH_HALT_FREEZE_EN aware).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode, W_icode;
  logic        M_Cnd;
  logic [63:0] M_valA, W_valM;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        imem_error;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP, F_predPC_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(64'h100)) dut (
    .clk        (clk),
    .rst        (rst),
    .F_stall    (F_stall),
    .D_stall    (D_stall),
    .D_bubble   (D_bubble),
    .M_icode    (M_icode),
    .M_Cnd      (M_Cnd),
    .M_valA     (M_valA),
    .W_icode    (W_icode),
    .W_valM     (W_valM),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_error (imem_error),
    .D_stat     (D_stat),
    .D_icode    (D_icode),
    .D_ifun     (D_ifun),
    .D_rA       (D_rA),
    .D_rB       (D_rB),
    .D_valC     (D_valC),
    .D_valP     (D_valP),
    .F_predPC_o (F_predPC_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [63:0] addr);
    M_icode = 4'h7;
    M_Cnd   = 1'b0;
    M_valA  = addr;
  endtask

  task automatic clear_redirect();
    M_icode = 4'h1;
    M_Cnd   = 1'b1;
    W_icode = 4'h1;
  endtask

  localparam logic [79:0] IRMOVQ_A = {56'h0, 8'h0A, 8'hF2, 8'h30};
  localparam logic [79:0] JMP_80   = {8'h00, 64'h80, 8'h70};
  localparam logic [79:0] BAD_C0   = {72'h0, 8'hC0};
  localparam logic [79:0] NOP_B    = {72'h0, 8'h10};
  localparam logic [79:0] ADDQ_01  = {64'h0, 8'h01, 8'h60};
  localparam logic [79:0] HALT_B   = 80'h0;

  initial begin
    rst = 1'b1; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    M_icode = 4'h1; M_Cnd = 1'b1; M_valA = 64'h0;
    W_icode = 4'h1; W_valM = 64'h0;
    imem_data = NOP_B; imem_error = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_addr",  imem_addr, 64'h100);
    check("rst_icode", D_icode,   64'h1);
    check("rst_stat",  D_stat,    64'h0);
    check("rst_rA",    D_rA,      64'hF);
    check("rst_rB",    D_rB,      64'hF);
    check("rst_valP",  D_valP,    64'h0);

    redirect(64'h0); imem_data = IRMOVQ_A; #1;
    check("redir_addr", imem_addr, 64'h0);
    @(negedge clk); clear_redirect(); imem_data = NOP_B; #1;
    check("irm_icode", D_icode,   64'h3);
    check("irm_rA",    D_rA,      64'hF);
    check("irm_rB",    D_rB,      64'h2);
    check("irm_valC",  D_valC,    64'hA);
    check("irm_valP",  D_valP,    64'hA);
    check("irm_stat",  D_stat,    64'h1);
    check("irm_addr",  imem_addr, 64'hA);

    redirect(64'h20); imem_data = JMP_80;
    @(negedge clk); clear_redirect(); imem_data = NOP_B; #1;
    check("jxx_pred",  F_predPC_o, 64'h80);
    check("jxx_addr",  imem_addr,  64'h80);
    check("jxx_icode", D_icode,    64'h7);
    check("jxx_valC",  D_valC,     64'h80);
    check("jxx_valP",  D_valP,     64'h29);
    redirect(64'h29); #1;
    check("mispred_addr", imem_addr, 64'h29);
    W_icode = 4'h9; W_valM = 64'h555; #1;
    check("both_addr", imem_addr, 64'h29);
    M_icode = 4'h1; M_Cnd = 1'b1; #1;
    check("ret_addr",  imem_addr, 64'h555);
    clear_redirect();

    redirect(64'h40); imem_data = BAD_C0;
    @(negedge clk); redirect(64'h50); imem_error = 1'b1; #1;
    check("ins_stat",  D_stat,  64'h4);
    check("ins_icode", D_icode, 64'hC);
    check("ins_valP",  D_valP,  64'h41);
    @(negedge clk); imem_error = 1'b0; clear_redirect(); imem_data = NOP_B; #1;
    check("adr_stat",  D_stat,  64'h3);
    check("adr_icode", D_icode, 64'h1);
    check("adr_valP",  D_valP,  64'h51);

    redirect(64'hFFFF_FFFF_FFFF_FFFE); imem_data = IRMOVQ_A;
    @(negedge clk); #1;
    check("wrap_valP", D_valP, 64'h8);
    check("wrap_valC", D_valC, 64'hA);

    redirect(64'h60); imem_data = NOP_B;
    @(negedge clk); clear_redirect(); imem_data = ADDQ_01; D_stall = 1'b1; D_bubble = 1'b1; #1;
    check("nop_valP", D_valP, 64'h61);
    @(negedge clk); #1;
    check("dstall_icode", D_icode,   64'h1);
    check("dstall_valP",  D_valP,    64'h61);
    check("dstall_addr",  imem_addr, 64'h63);
    D_stall = 1'b0; F_stall = 1'b1;
    @(negedge clk); #1;
    check("bubble_stat", D_stat,    64'h0);
    check("bubble_valP", D_valP,    64'h0);
    check("fstall_addr", imem_addr, 64'h63);
    F_stall = 1'b0; D_bubble = 1'b0;
    @(negedge clk); #1;
    check("opq_icode", D_icode, 64'h6);
    check("opq_rA",    D_rA,    64'h0);
    check("opq_rB",    D_rB,    64'h1);
    check("opq_valP",  D_valP,  64'h65);

    redirect(64'h70); imem_data = HALT_B;
    @(negedge clk); clear_redirect(); imem_data = NOP_B; #1;
    check("hlt_stat", D_stat,    64'h2);
    check("hlt_addr", imem_addr, 64'h71);
`ifdef FETCH_HALT_FREEZE_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("frz_stat", D_stat,    64'h0);
      check("frz_addr", imem_addr, 64'h71);
    end
    redirect(64'h90);
    @(negedge clk); clear_redirect(); #1;
    check("unfrz_stat", D_stat,    64'h1);
    check("unfrz_valP", D_valP,    64'h91);
    check("unfrz_addr", imem_addr, 64'h91);
`else
    @(negedge clk); #1;
    check("post_hlt_stat", D_stat,    64'h1);
    check("post_hlt_valP", D_valP,    64'h72);
    check("post_hlt_addr", imem_addr, 64'h72);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
